// File: rtl/bullet_pool.sv
// Multi-slot projectile manager: moves up to NUM_SLOTS bullets once per frame,
// retires them at the field edge or on a target hit, and owns the target's HP.
module bullet_pool #(
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = 12,
  parameter int Y_W       = 12,
  parameter int STEP      = 12,
  parameter int X_MIN     = -640,
  parameter int X_MAX     = 639,
  parameter int COOLDOWN  = 8,
  parameter int HP_WIDTH  = 3,
  parameter int HP_INIT   = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame,
  input  logic                     i_reload,
  input  logic                     i_fire,
  input  logic                     i_dir,
  input  logic [X_W-1:0]           i_spawn_x,
  input  logic [Y_W-1:0]           i_spawn_y,
  input  logic [X_W-1:0]           i_tgt_xmin,
  input  logic [X_W-1:0]           i_tgt_xmax,
  input  logic [Y_W-1:0]           i_tgt_ymin,
  input  logic [Y_W-1:0]           i_tgt_ymax,
  input  logic                     i_tgt_shield,
  output logic [NUM_SLOTS-1:0]     o_valid,
  output logic [NUM_SLOTS*X_W-1:0] o_bx,
  output logic [NUM_SLOTS*Y_W-1:0] o_by,
  output logic                     o_fire_ack,
  output logic                     o_fire_drop,
  output logic                     o_hit,
  output logic                     o_blocked,
  output logic [HP_WIDTH-1:0]      o_tgt_hp,
  output logic                     o_dead,
  output logic                     o_busy,
  output logic                     o_overrun
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;

  localparam logic signed [X_W:0]    STEP_E     = (X_W+1)'(STEP);
  localparam logic signed [X_W:0]    XMIN_E     = (X_W+1)'(X_MIN);
  localparam logic signed [X_W:0]    XMAX_E     = (X_W+1)'(X_MAX);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CD_W-1:0]        COOLDOWN_V = CD_W'(COOLDOWN);
  localparam logic [HP_WIDTH-1:0]    HP_INIT_V  = HP_WIDTH'(HP_INIT);

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [NUM_SLOTS-1:0]      valid;
  logic [NUM_SLOTS-1:0]      dir;
  logic signed [X_W-1:0]     bx [NUM_SLOTS];
  logic signed [Y_W-1:0]     by [NUM_SLOTS];
  logic [CD_W-1:0]           cooldown;
  logic                      pending;
  logic [HP_WIDTH-1:0]       hp;

  logic signed [X_W-1:0]     cur_x;
  logic signed [Y_W-1:0]     cur_y;
  logic signed [X_W:0]       cur_ext;
  logic signed [X_W:0]       nx;
  logic signed [X_W:0]       txmin_ext;
  logic signed [X_W:0]       txmax_ext;
  logic signed [Y_W-1:0]     tymin;
  logic signed [Y_W-1:0]     tymax;
  logic                      out_of_field;
  logic                      in_box;
  logic [HP_WIDTH-1:0]       hp_dec;
  logic                      free_found;
  logic [IDX_W-1:0]          free_idx;
  logic                      spawn_try;

  assign txmin_ext = {i_tgt_xmin[X_W-1], i_tgt_xmin};
  assign txmax_ext = {i_tgt_xmax[X_W-1], i_tgt_xmax};
  assign tymin     = i_tgt_ymin;
  assign tymax     = i_tgt_ymax;

  // Next position of the slot under the MOVE cursor, one bit wider so the edge test cannot wrap.
  always_comb begin
    cur_x        = bx[idx];
    cur_y        = by[idx];
    cur_ext      = {cur_x[X_W-1], cur_x};
    nx           = dir[idx] ? (cur_ext - STEP_E) : (cur_ext + STEP_E);
    out_of_field = (nx < XMIN_E) || (nx > XMAX_E);
    in_box       = (nx >= txmin_ext) && (nx <= txmax_ext) &&
                   (cur_y >= tymin) && (cur_y <= tymax);
    hp_dec       = (hp == '0) ? '0 : (hp - HP_WIDTH'(1));
  end

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      free_found = free_found | ~valid[k];
      free_idx   = valid[k] ? free_idx : IDX_W'(k);
    end
  end

  // A spawn attempt (ack or drop) consumes the pending request.
  assign spawn_try = (state == ST_SPAWN) && (cooldown == '0) && pending && !o_dead;

  // Frame FSM, slot storage, cooldown, HP and event pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      valid       <= '0;
      dir         <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        bx[k] <= '0;
        by[k] <= '0;
      end
      cooldown    <= '0;
      pending     <= 1'b0;
      hp          <= HP_INIT_V;
      o_fire_ack  <= 1'b0;
      o_fire_drop <= 1'b0;
      o_hit       <= 1'b0;
      o_blocked   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_fire_ack  <= 1'b0;
      o_fire_drop <= 1'b0;
      o_hit       <= 1'b0;
      o_blocked   <= 1'b0;
      if (i_reload) begin
        state    <= ST_IDLE;
        idx      <= '0;
        valid    <= '0;
        dir      <= '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          bx[k] <= '0;
          by[k] <= '0;
        end
        cooldown <= '0;
        pending  <= 1'b0;
        hp       <= HP_INIT_V;
      end else begin
        pending <= (pending & ~spawn_try) | (i_fire & ~o_dead);
        if (i_frame && (state != ST_IDLE)) begin
          o_overrun <= 1'b1;
        end
        case (state)
          ST_IDLE: begin
            if (i_frame) begin
              state <= ST_MOVE;
              idx   <= '0;
            end
          end
          ST_MOVE: begin
            if (valid[idx]) begin
              if (out_of_field) begin
                valid[idx] <= 1'b0;
              end else if (in_box) begin
                valid[idx] <= 1'b0;
                if (i_tgt_shield) begin
                  o_blocked <= 1'b1;
                end else begin
                  o_hit <= 1'b1;
                  hp    <= hp_dec;
                end
              end else begin
                bx[idx] <= nx[X_W-1:0];
              end
            end
            if (idx == LAST_IDX) begin
              state <= ST_SPAWN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ST_SPAWN: begin
            state <= ST_IDLE;
            if (cooldown != '0) begin
              cooldown <= cooldown - CD_W'(1);
            end else if (spawn_try) begin
              if (free_found) begin
                valid[free_idx] <= 1'b1;
                bx[free_idx]    <= i_spawn_x;
                by[free_idx]    <= i_spawn_y;
                dir[free_idx]   <= i_dir;
                o_fire_ack      <= 1'b1;
                cooldown        <= COOLDOWN_V;
              end else begin
                o_fire_drop <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign o_bx[g*X_W +: X_W] = bx[g];
    assign o_by[g*Y_W +: Y_W] = by[g];
  end

  assign o_valid  = valid;
  assign o_tgt_hp = hp;
  assign o_dead   = (hp == '0);
  assign o_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_bullet_pool.sv
// Directed self-checking bench for bullet_pool: a vector table of single-frame
// scenarios plus hand-written cooldown, death, reload and overrun sequences.
module tb_bullet_pool;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_frame = 1'b0;
  logic        i_reload = 1'b0;
  logic        i_fire = 1'b0;
  logic        i_dir = 1'b0;
  logic [11:0] i_spawn_x = 12'd0;
  logic [11:0] i_spawn_y = 12'd0;
  logic [11:0] i_tgt_xmin = 12'd2000;
  logic [11:0] i_tgt_xmax = 12'd2040;
  logic [11:0] i_tgt_ymin = -12'sd50;
  logic [11:0] i_tgt_ymax = 12'd50;
  logic        i_tgt_shield = 1'b0;
  logic [3:0]  o_valid;
  logic [47:0] o_bx;
  logic [47:0] o_by;
  logic        o_fire_ack, o_fire_drop, o_hit, o_blocked;
  logic [2:0]  o_tgt_hp;
  logic        o_dead, o_busy, o_overrun;

  bullet_pool dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame(i_frame), .i_reload(i_reload),
    .i_fire(i_fire), .i_dir(i_dir), .i_spawn_x(i_spawn_x), .i_spawn_y(i_spawn_y),
    .i_tgt_xmin(i_tgt_xmin), .i_tgt_xmax(i_tgt_xmax),
    .i_tgt_ymin(i_tgt_ymin), .i_tgt_ymax(i_tgt_ymax), .i_tgt_shield(i_tgt_shield),
    .o_valid(o_valid), .o_bx(o_bx), .o_by(o_by),
    .o_fire_ack(o_fire_ack), .o_fire_drop(o_fire_drop), .o_hit(o_hit),
    .o_blocked(o_blocked), .o_tgt_hp(o_tgt_hp), .o_dead(o_dead),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rl; logic fi; logic dr; int sx; int sy; int box; logic sh;
    int e_ack; int e_hit; int e_blk; int e_valid; int e_hp; logic chk_x; int e_x0;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int f_ack, f_drop, f_hit, f_blk;
  int sum_ack, sum_drop, sum_hit;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic rl, input logic fi, input logic dr, input int sx, input int sy,
                     input int box, input logic sh, input int e_ack, input int e_hit,
                     input int e_blk, input int e_valid, input int e_hp, input logic chk_x,
                     input int e_x0);
    vec_t v;
    v = '{rl, fi, dr, sx, sy, box, sh, e_ack, e_hit, e_blk, e_valid, e_hp, chk_x, e_x0};
    vecs.push_back(v);
  endtask

  task automatic set_target(input int xmin, input int xmax, input int ymin, input int ymax);
    i_tgt_xmin = 12'(xmin);
    i_tgt_xmax = 12'(xmax);
    i_tgt_ymin = 12'(ymin);
    i_tgt_ymax = 12'(ymax);
  endtask

  task automatic do_reload();
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
  endtask

  task automatic pulse_fire();
    i_fire = 1'b1;
    tick();
    i_fire = 1'b0;
  endtask

  // One full frame: i_frame cycle plus NUM_SLOTS MOVE cycles and the SPAWN cycle.
  task automatic run_frame();
    f_ack = 0; f_drop = 0; f_hit = 0; f_blk = 0;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    chk("busy_start", int'(o_busy), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      f_ack  += int'(o_fire_ack);
      f_drop += int'(o_fire_drop);
      f_hit  += int'(o_hit);
      f_blk  += int'(o_blocked);
    end
    chk("busy_end", int'(o_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_hp", int'(o_tgt_hp), 5);
    chk("rst_dead", int'(o_dead), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    chk("rst_pulses", int'({o_fire_ack, o_fire_drop, o_hit, o_blocked}), 0);
    chk("rst_bx", int'(|o_bx), 0);
    chk("rst_by", int'(|o_by), 0);

    // rl fi dr sx sy box sh | ack hit blk valid hp chk_x x0
    add(1, 1, 0,    0,  0, 0, 0, 1, 0, 0, 1, 5, 1,    0);
    add(0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 1, 5, 1,   12);
    add(0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 1, 5, 1,   24);
    add(1, 1, 0,  627,  0, 0, 0, 1, 0, 0, 1, 5, 1,  627);
    add(0, 0, 0,  627,  0, 0, 0, 0, 0, 0, 1, 5, 1,  639);
    add(0, 0, 0,  627,  0, 0, 0, 0, 0, 0, 0, 5, 0,    0);
    add(1, 1, 1, -628,  0, 0, 0, 1, 0, 0, 1, 5, 1, -628);
    add(0, 0, 1, -628,  0, 0, 0, 0, 0, 0, 1, 5, 1, -640);
    add(0, 0, 1, -628,  0, 0, 0, 0, 0, 0, 0, 5, 0,    0);
    add(1, 1, 0,  630,  0, 0, 0, 1, 0, 0, 1, 5, 1,  630);
    add(0, 0, 0,  630,  0, 0, 0, 0, 0, 0, 0, 5, 0,    0);
    add(1, 1, 0,   90,  0, 1, 0, 1, 0, 0, 1, 5, 1,   90);
    add(0, 0, 0,   90,  0, 1, 0, 0, 1, 0, 0, 4, 0,    0);
    add(1, 1, 0,   90,  0, 1, 1, 1, 0, 0, 1, 5, 1,   90);
    add(0, 0, 0,   90,  0, 1, 1, 0, 0, 1, 0, 5, 0,    0);
    add(1, 1, 0,   90, 60, 1, 0, 1, 0, 0, 1, 5, 1,   90);
    add(0, 0, 0,   90, 60, 1, 0, 0, 0, 0, 1, 5, 1,  102);
    add(1, 1, 0,   90, 50, 1, 0, 1, 0, 0, 1, 5, 1,   90);
    add(0, 0, 0,   90, 50, 1, 0, 0, 1, 0, 0, 4, 0,    0);
    add(1, 1, 0,   88,  0, 1, 0, 1, 0, 0, 1, 5, 1,   88);
    add(0, 0, 0,   88,  0, 1, 0, 0, 1, 0, 0, 4, 0,    0);
    add(1, 1, 0,  128,  0, 1, 0, 1, 0, 0, 1, 5, 1,  128);
    add(0, 0, 0,  128,  0, 1, 0, 0, 1, 0, 0, 4, 0,    0);
    add(1, 1, 0,  129,  0, 1, 0, 1, 0, 0, 1, 5, 1,  129);
    add(0, 0, 0,  129,  0, 1, 0, 0, 0, 0, 1, 5, 1,  141);
    add(1, 1, 1,  150,  0, 1, 0, 1, 0, 0, 1, 5, 1,  150);
    add(0, 0, 1,  150,  0, 1, 0, 0, 1, 0, 0, 4, 0,    0);

    foreach (vecs[n]) begin
      i_dir        = vecs[n].dr;
      i_spawn_x    = 12'(vecs[n].sx);
      i_spawn_y    = 12'(vecs[n].sy);
      i_tgt_shield = vecs[n].sh;
      if (vecs[n].box == 1) set_target(100, 140, -50, 50);
      else                  set_target(2000, 2040, -50, 50);
      if (vecs[n].rl) do_reload();
      if (vecs[n].fi) pulse_fire();
      run_frame();
      chk($sformatf("v%0d_ack", n), f_ack, vecs[n].e_ack);
      chk($sformatf("v%0d_drop", n), f_drop, 0);
      chk($sformatf("v%0d_hit", n), f_hit, vecs[n].e_hit);
      chk($sformatf("v%0d_blk", n), f_blk, vecs[n].e_blk);
      chk($sformatf("v%0d_valid", n), int'(o_valid), vecs[n].e_valid);
      chk($sformatf("v%0d_hp", n), int'(o_tgt_hp), vecs[n].e_hp);
      if (vecs[n].chk_x) chk($sformatf("v%0d_x0", n), int'($signed(o_bx[11:0])), vecs[n].e_x0);
    end

    // Cooldown: firing every frame gives acks 9 frames apart; 5th shot with 4 live slots drops.
    i_tgt_shield = 1'b0;
    set_target(2000, 2040, -50, 50);
    i_dir = 1'b0; i_spawn_x = 12'd0; i_spawn_y = 12'd0;
    do_reload();
    for (int f = 1; f <= 37; f++) begin
      pulse_fire();
      run_frame();
      chk($sformatf("cd_f%0d_ack", f), f_ack, ((f % 9 == 1) && (f <= 28)) ? 1 : 0);
      chk($sformatf("cd_f%0d_drop", f), f_drop, (f == 37) ? 1 : 0);
    end
    chk("cd_valid_full", int'(o_valid), 15);

    // Death: bullet A at y=200 flies past the box while shots at x=90 drain HP.
    do_reload();
    set_target(100, 140, -50, 50);
    i_spawn_x = 12'd0; i_spawn_y = 12'd200;
    pulse_fire();
    run_frame();
    chk("dead_a_ack", f_ack, 1);
    i_spawn_x = 12'd90; i_spawn_y = 12'd0;
    sum_ack = 0; sum_hit = 0;
    for (int f = 2; f <= 47; f++) begin
      pulse_fire();
      run_frame();
      sum_ack += f_ack;
      sum_hit += f_hit;
    end
    chk("dead_acks", sum_ack, 5);
    chk("dead_hits", sum_hit, 5);
    chk("dead_hp", int'(o_tgt_hp), 0);
    chk("dead_flag", int'(o_dead), 1);
    chk("dead_a_alive", int'(o_valid), 1);
    chk("dead_a_x", int'($signed(o_bx[11:0])), 552);
    set_target(-2048, 2047, 150, 250);
    pulse_fire();
    run_frame();
    chk("dead_late_hit", f_hit, 1);
    chk("dead_hp_sat", int'(o_tgt_hp), 0);
    chk("dead_late_valid", int'(o_valid), 0);
    set_target(2000, 2040, -50, 50);
    sum_ack = 0; sum_drop = 0;
    for (int f = 0; f < 10; f++) begin
      pulse_fire();
      run_frame();
      sum_ack  += f_ack;
      sum_drop += f_drop;
    end
    chk("dead_no_ack", sum_ack, 0);
    chk("dead_no_drop", sum_drop, 0);
    do_reload();
    chk("reload_hp", int'(o_tgt_hp), 5);
    chk("reload_dead", int'(o_dead), 0);
    chk("reload_valid", int'(o_valid), 0);

    // i_frame coincident with i_reload is ignored.
    i_reload = 1'b1; i_frame = 1'b1;
    tick();
    i_reload = 1'b0; i_frame = 1'b0;
    chk("reload_frame_busy", int'(o_busy), 0);
    tick();
    chk("reload_frame_busy2", int'(o_busy), 0);
    chk("pre_overrun", int'(o_overrun), 0);

    // Overrun: i_frame during the second MOVE cycle is dropped and flagged.
    i_spawn_x = 12'd0;
    pulse_fire();
    run_frame();
    chk("ovr_ack", f_ack, 1);
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    tick();
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    repeat (3) tick();
    chk("ovr_busy", int'(o_busy), 0);
    chk("ovr_flag", int'(o_overrun), 1);
    tick();
    chk("ovr_busy_after", int'(o_busy), 0);
    chk("ovr_x_once", int'($signed(o_bx[11:0])), 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
